// File: rtl/add_seq.sv
// Multi-precision add/subtract sequencer: one shared 16-bit slice adder per
// cycle, least-significant slice first, with the inter-slice carry registered.

module add_seq_slice16 (
  output logic [15:0] out,
  output logic        carry,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c0
);

  assign {carry, out} = {1'b0, a} + {1'b0, b} + {16'h0000, c0};

endmodule

module add_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op_sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                carry_out,
  output logic                overflow
);

  localparam int unsigned W  = 16 * WORDS;
  localparam int unsigned IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;

  logic            w_accept;
  logic            w_last;
  logic [IW+3:0]   w_lsb;
  logic [15:0]     w_sa;
  logic [15:0]     w_sb;
  logic [15:0]     w_ss;
  logic            w_sc;
  logic            w_ovf;

  assign w_accept = (r_state != S_RUN) && start;
  assign w_last   = (r_idx == IW'(WORDS - 1));
  assign w_lsb    = {r_idx, 4'h0};
  assign w_sa     = r_a[w_lsb +: 16];
  assign w_sb     = r_b[w_lsb +: 16];

  add_seq_slice16 u_slice (
    .out   (w_ss),
    .carry (w_sc),
    .a     (w_sa),
    .b     (w_sb),
    .c0    (r_carry)
  );

  // Signed overflow: carry into the top bit differs from the carry out of it.
  assign w_ovf = (w_sa[15] ^ w_sb[15] ^ w_ss[15]) ^ w_sc;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= op_sub ? ~b : b;
      r_carry <= op_sub;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sum[w_lsb +: 16] <= w_ss;
      r_carry            <= w_sc;
      if (w_last) begin
        r_cout <= w_sc;
        r_ovf  <= w_ovf;
      end else begin
        r_idx  <= r_idx + IW'(1);
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench for add_seq (WORDS=4): directed vectors push expected
// results; a negedge monitor pops and compares on every done pulse.

module tb_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [W+1:0] e;
      done_cnt++;
      chk("busy_in_done", W'(busy), W'(0));
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard expected none");
      end else begin
        e = exp_q.pop_front();
        chk("sum", sum, e[W+1:2]);
        chk("carry_out", W'(carry_out), W'(e[1]));
        chk("overflow", W'(overflow), W'(e[0]));
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  // ign_at > 0 pulses a conflicting start during that RUN cycle.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input int ign_at);
    int cnt;
    int bcnt;
    bit seen;
    cnt  = 0;
    bcnt = 0;
    seen = 0;
    exp_q.push_back({es, ec, eo});
    a = va; b = vb; op_sub = vs; start = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cnt++;
      start = 1'b0;
      if (ign_at > 0 && cnt == ign_at) begin
        a = '0; b = '0; op_sub = 1'b1; start = 1'b1;
      end
      if (cnt == 1) chk("busy_first_run", W'(busy), W'(1));
      if (busy) bcnt++;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("done_latency", W'(cnt), W'(WORDS + 1));
    chk("busy_cycles", W'(bcnt), W'(WORDS));
  endtask

  initial begin
    int d0;
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    #23;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_sum", sum, '0);
    chk("rst_cout", W'(carry_out), W'(0));
    chk("rst_ovf", W'(overflow), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 0);
    @(negedge clk);
    run_op(64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0);
    @(negedge clk);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
    @(negedge clk);
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);
    @(negedge clk);
    run_op(64'h0001_0000_FFFF_8000, 64'h0000_FFFF_0001_8000, 1'b0,
           64'h0002_0000_0001_0000, 1'b0, 1'b0, 0);
    @(negedge clk);
    run_op(64'h0000_0000_0001_0000, 64'h1, 1'b1, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 0);
    @(negedge clk);

    d0 = done_cnt;
    run_op(64'h1234, 64'h1, 1'b0, 64'h1235, 1'b0, 1'b0, 2);
    repeat (6) @(negedge clk);
    chk("ignored_start_done_count", W'(done_cnt - d0), W'(1));

    run_op(64'h2, 64'h2, 1'b0, 64'h4, 1'b0, 1'b0, 0);
    run_op(64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0, 0);
    run_op(64'h5, 64'h8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 0);
    @(negedge clk);

    a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_sum", sum, '0);
    chk("abort_cout", W'(carry_out), W'(0));
    chk("abort_ovf", W'(overflow), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    chk("abort_no_done", W'(done_cnt - d0), W'(0));
    run_op(64'hFFFF, 64'h1, 1'b0, 64'h1_0000, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_seq.md
# add_seq

Multi-cycle multi-precision add/subtract sequencer. It computes a 16·WORDS-bit sum or difference by driving one shared 16-bit slice adder once per cycle, least-significant slice first, and chains the carry through a register. It sits beside the Add16/Add32 datapath. Use it where full-width combinational adders cost too much area, for example wide accumulators and address or offset arithmetic in the CPU.

## Interface
- WORDS, default 4: number of 16-bit slices. Operand width is W = 16·WORDS. Legal range is 2..16.
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request. Sampled only when the block is not busy.
- op_sub, input, 1: 0 selects a+b; 1 selects a−b.
- a, input, W: operand A. Captured on an accepted start.
- b, input, W: operand B. Captured on an accepted start.
- busy, output, 1: high while slices are being computed.
- done, output, 1: one-cycle pulse when the result is valid.
- sum, output, W: result register. Held until the next accepted start.
- carry_out, output, 1: carry out of the MSB. For subtract it is the not-borrow flag (1 = no borrow).
- overflow, output, 1: two's-complement signed overflow of the full-width operation.

## Operation
- Reset-state outputs:
  - busy=0, done=0, sum=0, carry_out=0, overflow=0.
  - State is IDLE; slice index is 0; carry register is 0.
- FSM states are IDLE, RUN and DONE.
- IDLE, or DONE, with start=1 (accepted start):
  - Latch a into the A register.
  - Latch b into the B register, or ~b when op_sub=1.
  - Set the carry register to op_sub.
  - Set the index to 0.
  - Clear sum, carry_out and overflow.
  - Go to RUN.
- RUN, each cycle:
  - The slice adder takes A[16i+15:16i], B[16i+15:16i] and the carry register, where i is the index.
  - Write the 16-bit result into sum[16i+15:16i].
  - Load the slice carry-out into the carry register.
  - Increment i.
- RUN, when i = WORDS−1:
  - Also load carry_out from the slice carry-out.
  - Load overflow = (carry into bit 15 of the slice) XOR (slice carry-out). The carry into bit 15 is A[W−1]^B[W−1]^slice_sum[15], using the already-inverted B.
  - Go to DONE.
- DONE lasts one cycle with done=1.
  - Without start, go to IDLE.
  - With start, accept it and go to RUN. Back-to-back operation is legal.
- busy = (state == RUN). done = (state == DONE). Both are registered state decodes, with no combinational path from start.
- start while busy=1 is ignored: no latch and no effect on the operation in progress. There is no queueing.
- a, b and op_sub are don't-care except in the cycle where a start is accepted.
- The slice adder is a 16-bit adder with carry-in and carry-out (ports out, carry, a, b, c0, per Add16). c0 must be honoured on every slice, the first slice included.
- Reset asserted mid-operation:
  - Immediately abort to IDLE.
  - All outputs return to their reset values.
  - No done pulse is produced for the aborted operation.

## Timing
- Latency: a start accepted at edge k gives slices at edges k+1..k+WORDS.
  - done=1 in the cycle following edge k+WORDS.
  - Throughput is one operation per WORDS+1 cycles.
- sum slices update progressively during RUN. sum, carry_out and overflow are guaranteed valid only from the done cycle until the next accepted start.
- Critical path: one 16-bit slice add plus the register setup. The W-bit carry chain is never combinational.

## Test plan
- Add with full carry ripple:
  - Stimulus: WORDS=4, a=0xFFFF_FFFF_FFFF_FFFF, b=1, op_sub=0.
  - Required: sum=0, carry_out=1, overflow=0; busy high for 4 cycles; done pulses exactly 5 cycles after start is sampled.
- Subtract with borrow: a=0, b=1, op_sub=1 → sum=0xFFFF_FFFF_FFFF_FFFF, carry_out=0, overflow=0.
- Signed overflow, both directions:
  - a=0x7FFF_FFFF_FFFF_FFFF + 1 → sum=0x8000_0000_0000_0000, overflow=1, carry_out=0.
  - a=0x8000_0000_0000_0000 − 1 → sum=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Ignored start:
  - Stimulus: start an add of 0x1234 + 0x1 with op_sub=0. During cycle 2 of RUN, pulse start with a=0, b=0, op_sub=1.
  - Required: result 0x1235; only one done pulse; busy stays continuously high for exactly 4 cycles.
- Back-to-back:
  - Stimulus: assert start in the done cycle with 5+3.
  - Required: done for the prior result pulses; the new RUN begins next cycle; the second done gives sum=8; busy is never high during either done cycle.
- Reset abort: drop rst_n in the middle of RUN → busy, done, sum, carry_out and overflow are 0 asynchronously; no done pulse after release; the next start completes normally.
